// File: rtl/mfu_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mfu_serial_ctrl (with its 1-bit helper mfu)
//  Purpose  : Bit-serial sequencer that pushes WIDTH-bit operand words one bit
//             per cycle, LSB first, through a single 1-bit multi-function unit
//             and returns the assembled word over a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================

// 1-bit multi-function logic unit shared by the sequencer.
module mfu (
    input  logic       a_i,
    input  logic       b_i,
    input  logic [2:0] sel_i,
    output logic       y_o
);
    // Function select: the reserved code 3'b111 yields 0.
    always_comb begin
        y_o = 1'b0;
        case (sel_i)
            3'b000:  y_o = a_i & b_i;
            3'b001:  y_o = a_i | b_i;
            3'b010:  y_o = ~a_i;
            3'b011:  y_o = ~(a_i & b_i);
            3'b100:  y_o = ~(a_i | b_i);
            3'b101:  y_o = a_i ^ b_i;
            3'b110:  y_o = ~(a_i ^ b_i);
            default: y_o = 1'b0;
        endcase
    end
endmodule

module mfu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       op_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    localparam int                CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             mfu_y;
    logic [WIDTH-1:0] sh_next;

    // The single shared bit-level unit, fed from the latched operands.
    mfu u_mfu (
        .a_i   (a_q[cnt_q]),
        .b_i   (b_q[cnt_q]),
        .sel_i (sel_q),
        .y_o   (mfu_y)
    );

    // New bits enter at the MSB so the first (LSB) result bit lands at bit 0
    // after WIDTH shifts.
    assign sh_next = {mfu_y, sh_q[WIDTH-1:1]};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            sh_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            result_q <= result_d;
        end
    end

    // Next-state and datapath update; operands are captured only at acceptance.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    sel_d   = op_sel;
                    cnt_d   = '0;
                    sh_d    = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sh_d = sh_next;
                if (cnt_q == C_LAST) begin
                    // Publish only the complete word; counter holds, no wrap.
                    result_d = sh_next;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decode state only; in_ready is masked while in reset.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign result    = result_q;

endmodule
`default_nettype wire
